// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Definitions shared by the frame buffer writer and the pixel fetcher, so that
// both sides agree on the frame size and on the per-bank address map.
//   fb_state_t  : writer FSM states (FILL, WAIT_SWAP)
//   FRAME_WORDS : image RAM words per frame (640x480, 4 pixels per word)
//   OFS_W       : per-bank word-offset width
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int FRAME_WORDS = 76800;
    localparam int OFS_W       = 17;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_t;

endpackage : vga_pkg

// File: rtl/frame_buffer_writer.sv
// ----------------------------------------------------------------------------
// frame_buffer_writer
// Writes a processed-pixel stream into the back bank of a double-buffered
// image RAM. The front bank (disp_bank) is only swapped at a vertical-blank
// boundary after a complete frame has been written, so the display never
// shows a partially written image.
//
// Ports
//   clk           pixel clock (shared with VGA counters and image RAM)
//   rst           asynchronous active-low reset
//   enable        swap enable; frames are still written when low
//   vs_start      one-cycle pulse at the start of vertical blank
//   in_valid      stream word valid
//   in_data       stream word (packed pixels)
//   in_last       final word of a frame
//   in_ready      writer can accept a word (registered)
//   wr_en         image RAM write strobe
//   wr_addr       image RAM write address {write bank, offset}
//   wr_data       image RAM write data
//   disp_bank     front bank, selects the image the pixel fetcher reads
//   frame_swapped one-cycle pulse when disp_bank toggles
//   err_frame     sticky: in_last position disagreed with FRAME_WORDS
// ----------------------------------------------------------------------------
module frame_buffer_writer #(
    parameter int DATA_W      = 32,
    parameter int OFS_W       = vga_pkg::OFS_W,
    parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              vs_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [OFS_W:0]    wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              disp_bank,
    output logic              frame_swapped,
    output logic              err_frame
);

    import vga_pkg::*;

    localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(FRAME_WORDS - 1);

    fb_state_t         r_state;
    fb_state_t         w_next_state;
    logic [OFS_W-1:0]  r_offset;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [OFS_W:0]    r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_disp_bank;
    logic              r_frame_swapped;
    logic              r_err_frame;

    logic              w_hs;
    logic              w_at_end;
    logic              w_final;

    // A word is taken only in FILL while the registered ready is high.
    assign w_hs     = in_valid && r_in_ready && (r_state == FILL);
    assign w_at_end = (r_offset == LAST_OFS);
    // The frame ends on whichever comes first: in_last or the last offset.
    assign w_final  = w_hs && (in_last || w_at_end);

    // Next-state decode for the fill / wait-for-vblank FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL: begin
                if (w_final) begin
                    w_next_state = WAIT_SWAP;
                end else begin
                    w_next_state = FILL;
                end
            end
            WAIT_SWAP: begin
                if (vs_start) begin
                    w_next_state = FILL;
                end else begin
                    w_next_state = WAIT_SWAP;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    // State register, offset counter, bank select and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= FILL;
            r_offset        <= {OFS_W{1'b0}};
            r_in_ready      <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= {(OFS_W + 1){1'b0}};
            r_wr_data       <= {DATA_W{1'b0}};
            r_disp_bank     <= 1'b0;
            r_frame_swapped <= 1'b0;
            r_err_frame     <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_wr_en         <= w_hs;
            r_frame_swapped <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_hs) begin
                        // Writes always go to the back bank.
                        r_wr_addr <= {~r_disp_bank, r_offset};
                        r_wr_data <= in_data;
                        if (in_last != w_at_end) begin
                            r_err_frame <= 1'b1;
                        end
                        // Hold the offset on the final word so it never wraps.
                        if (w_final) begin
                            r_in_ready <= 1'b0;
                        end else begin
                            r_offset   <= r_offset + OFS_W'(1);
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        // Also gives the first-cycle ready rise after reset.
                        r_in_ready <= 1'b1;
                    end
                end
                WAIT_SWAP: begin
                    if (vs_start) begin
                        r_offset   <= {OFS_W{1'b0}};
                        r_in_ready <= 1'b1;
                        // With swapping disabled the back bank is simply
                        // overwritten by the next frame.
                        if (enable) begin
                            r_disp_bank     <= ~r_disp_bank;
                            r_frame_swapped <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign disp_bank     = r_disp_bank;
    assign frame_swapped = r_frame_swapped;
    assign err_frame     = r_err_frame;

endmodule : frame_buffer_writer
